seq_magnitude_comparator: RTL and testbench

Multi-cycle, parametrised magnitude comparator. It generalises the 4-bit combinational comparator to WIDTH-bit operands.
- Operands are compared MSB-first, one DIGIT-bit slice per clock, with early termination on the first differing slice.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake and registered, held result flags.
- Intended for datapaths where a wide single-cycle compare would break timing.

---
 rtl/seq_magnitude_comparator.sv | 106 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans both operands MSB-first, DIGIT bits per
// clock, and stops at the first differing slice. Signed mode uses offset binary.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_eq_B,
  output logic             A_ls_B
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COMPARE = 1'b1;

  // Flipping the sign bit maps two's complement onto offset binary, so an
  // unsigned slice compare gives the signed ordering.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_ls;

  logic [DIGIT-1:0] w_slice_a;
  logic [DIGIT-1:0] w_slice_b;
  logic             w_last;

  assign w_slice_a = r_a[WIDTH-1 -: DIGIT];
  assign w_slice_b = r_b[WIDTH-1 -: DIGIT];
  assign w_last    = (r_cnt == CW'(N - 1));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_ls    <= 1'b0;
    end else begin
      // NOTE: done defaults low every edge, which makes it a single-cycle pulse.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= signed_mode ? (A ^ SIGN_MASK) : A;
            r_b     <= signed_mode ? (B ^ SIGN_MASK) : B;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_slice_a != w_slice_b) begin
            r_gt    <= (w_slice_a > w_slice_b);
            r_eq    <= 1'b0;
            r_ls    <= (w_slice_a < w_slice_b);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b1;
            r_ls    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign A_gt_B = r_gt;
  assign A_eq_B = r_eq;
  assign A_ls_B = r_ls;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: a 16/4 instance with directed and random
// compares, and an 8/8 single-slice instance checked against a reference model.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;

  // 16-bit, 4-bit-slice instance
  logic        a_start, a_sm;
  logic [15:0] a_A, a_B;
  logic        a_busy, a_done, a_gt, a_eq, a_ls;

  // 8-bit, single-slice instance
  logic        b_start, b_sm;
  logic [7:0]  b_A, b_B;
  logic        b_busy, b_done, b_gt, b_eq, b_ls;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(a_start), .signed_mode(a_sm), .A(a_A), .B(a_B),
    .busy(a_busy), .done(a_done), .A_gt_B(a_gt), .A_eq_B(a_eq), .A_ls_B(a_ls)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(b_start), .signed_mode(b_sm), .A(b_A), .B(b_B),
    .busy(b_busy), .done(b_done), .A_gt_B(b_gt), .A_eq_B(b_eq), .A_ls_B(b_ls)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from plain signed/unsigned arithmetic; latency from the
  // position of the first differing 4-bit digit, counted from the top.
  function automatic logic [2:0] ref_flags16(input logic [15:0] a, input logic [15:0] b,
                                             input logic sm);
    logic gt, ls;
    gt = sm ? ($signed(a) > $signed(b)) : (a > b);
    ls = sm ? ($signed(a) < $signed(b)) : (a < b);
    return {gt, (a == b), ls};
  endfunction

  function automatic int ref_latency16(input logic [15:0] a, input logic [15:0] b);
    for (int s = 0; s < 4; s++)
      if (((a >> (12 - 4 * s)) & 16'hF) != ((b >> (12 - 4 * s)) & 16'hF)) return s + 1;
    return 4;
  endfunction

  function automatic logic [2:0] ref_flags8(input logic [7:0] a, input logic [7:0] b,
                                            input logic sm);
    int ia, ib;
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    return {(ia > ib), (ia == ib), (ia < ib)};
  endfunction

  // Called #1 after a rising edge; capture happens on the next edge.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    a_A = a; a_B = b; a_sm = sm; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("busy_after_capture", 32'(a_busy), 32'd1);
  endtask

  // Waits for done, checking busy on the way; optionally pokes start with
  // fresh operands during the first two busy cycles.
  task automatic wait16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sm, input bit disturb);
    int k = 0;
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (disturb && c < 2) begin
        a_start = 1'b1; a_A = 16'($urandom); a_B = 16'($urandom); a_sm = ~sm;
      end else begin
        a_start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (a_done) seen = 1;
      else check({tag, "_busy"}, 32'(a_busy), 32'd1);
    end
    a_start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(ref_latency16(a, b)));
    check({tag, "_flags"}, 32'({a_gt, a_eq, a_ls}), 32'(ref_flags16(a, b, sm)));
    check({tag, "_busy_at_done"}, 32'(a_busy), 32'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sm);
    start16(a, b, sm);
    wait16(tag, a, b, sm, 1'b0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    b_A = a; b_B = b; b_sm = sm; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_A = ~a;
    @(posedge clk); #1;
    check("w8_done", 32'(b_done), 32'd1);
    check("w8_flags", 32'({b_gt, b_eq, b_ls}), 32'(ref_flags8(a, b, sm)));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    a_start = 1'b0; a_sm = 1'b0; a_A = '0; a_B = '0;
    b_start = 1'b0; b_sm = 1'b0; b_A = '0; b_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state16", 32'({a_busy, a_done, a_gt, a_eq, a_ls}), 32'd0);
    check("reset_state8", 32'({b_busy, b_done, b_gt, b_eq, b_ls}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_flags_zero", 32'({a_busy, a_done, a_gt, a_eq, a_ls}), 32'd0);

    // Equal operands, full scan
    run16("eq_1234", 16'h1234, 16'h1234, 1'b0);
    // Top slice decides; sign mode flips the answer
    run16("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0);
    run16("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1);
    run16("u_12f4_1204", 16'h12F4, 16'h1204, 1'b0);
    run16("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1);
    run16("s_0000_ffff", 16'h0000, 16'hFFFF, 1'b1);
    run16("u_0000_ffff", 16'h0000, 16'hFFFF, 1'b0);

    // start during busy is ignored, operands are not re-sampled
    start16(16'h0001, 16'h0002, 1'b0);
    wait16("ignore_start", 16'h0001, 16'h0002, 1'b0, 1'b1);

    // Reset on the second compare edge aborts with no done
    start16(16'h0001, 16'h0002, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", 32'({a_busy, a_done, a_gt, a_eq, a_ls}), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'({a_done, a_busy}), 32'd0);
    end
    run16("after_abort", 16'h0001, 16'h0002, 1'b0);

    // Back-to-back: new start in the done cycle
    start16(16'hA5A5, 16'hA5A0, 1'b0);
    wait16("b2b_first", 16'hA5A5, 16'hA5A0, 1'b0, 1'b0);
    check("b2b_done_cycle", 32'(a_done), 32'd1);
    start16(16'h7000, 16'h7001, 1'b1);
    wait16("b2b_second", 16'h7000, 16'h7001, 1'b1, 1'b0);

    // Random compares; shared prefixes exercise every latency
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = {ra[15:12], rb[11:0]};
        2: rb = {ra[15:8], rb[7:0]};
        3: rb = {ra[15:4], rb[3:0]};
        default: ;
      endcase
      run16("rand16", ra, rb, rs);
    end

    // Single-slice instance: corners plus random pairs in both modes
    run8(8'h00, 8'h00, 1'b0);
    run8(8'h80, 8'h7F, 1'b0);
    run8(8'h80, 8'h7F, 1'b1);
    run8(8'hFF, 8'h00, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h01, 8'hFF, 1'b0);
    for (int i = 0; i < 600; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
